rgb_fade_sequencer: RTL

Colour-command sequencer that sits directly upstream of the 8-bit RGB PWM generator. It accepts target colours through a valid/ready interface and buffers them in a small FIFO. It ramps its registered r/g/b duty outputs one LSB per step tick toward each target, then holds the target for a programmable number of ticks before taking the next command. The r/g/b duty outputs drive the PWM comparators: pwm_count < duty.

---
 rtl/rgb_fade_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rgb_fade_sequencer.sv
// Colour-command sequencer: FIFO-buffered RGB targets, one-LSB-per-tick fades,
// then a programmable hold, feeding the 8-bit PWM comparators (pwm_count < duty).

module rgb_fade_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       step,
  output logic [7:0] duty,
  output logic       at_tgt
);
  logic [7:0] tgt;

  // Compare before stepping so the duty can never wrap past 0 or 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty <= '0;
      tgt  <= '0;
    end else begin
      if (load) tgt <= load_val;
      if (step && duty != tgt)
        duty <= (duty < tgt) ? duty + 8'd1 : duty - 8'd1;
    end
  end

  assign at_tgt = (duty == tgt);
endmodule

module rgb_fade_sequencer #(
  parameter int CLK_FREQ   = 12000000,
  parameter int STEP_HZ    = 360,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [23:0]                   cmd_rgb,
  input  logic [7:0]                    cmd_hold,
  output logic [7:0]                    r_duty,
  output logic [7:0]                    g_duty,
  output logic [7:0]                    b_duty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);
  localparam int NUM_LANES     = 3;
  localparam int STEP_INTERVAL = CLK_FREQ / STEP_HZ;
  localparam int TW            = $clog2(STEP_INTERVAL);
  localparam int AW            = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;

  state_t                          state;
  logic [TW-1:0]                   tick_cnt;
  logic                            tick;
  logic [31:0]                     mem [FIFO_DEPTH];
  logic [AW-1:0]                   wr_ptr, rd_ptr;
  logic [AW:0]                     count;
  logic                            full, push, pop;
  logic [31:0]                     head;
  logic [NUM_LANES-1:0][7:0]       tgt_in;
  logic [NUM_LANES-1:0][7:0]       duty;
  logic [NUM_LANES-1:0]            at_tgt;
  logic                            all_at, step;
  logic [7:0]                      hold_len, hold_cnt;

  // Free-running step timebase, deliberately not aligned to command arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end
  assign tick = (tick_cnt == TW'(STEP_INTERVAL - 1));

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign head      = mem[rd_ptr];
  assign tgt_in    = head[31:8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_rgb, cmd_hold};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rgb_fade_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .load     (pop),
      .load_val (tgt_in[i]),
      .step     (step),
      .duty     (duty[i]),
      .at_tgt   (at_tgt[i])
    );
  end

  assign all_at = &at_tgt;
  assign step   = (state == FADE) && tick && !all_at;

  // A target already matching the duties leaves FADE on the entry cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_len <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          hold_len <= head[7:0];
          state    <= FADE;
        end
        FADE: if (all_at) begin
          if (hold_len == 8'd0) state <= IDLE;
          else begin
            hold_cnt <= hold_len;
            state    <= HOLD;
          end
        end
        HOLD: if (tick) begin
          hold_cnt <= hold_cnt - 8'd1;
          if (hold_cnt == 8'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign r_duty     = duty[2];
  assign g_duty     = duty[1];
  assign b_duty     = duty[0];
  assign fifo_count = count;
  assign busy       = (state != IDLE) || (count != '0);
endmodule
